// File: rtl/debounce_pkg.sv
// Shared types and clock constants for the button conditioning path.
// Cycle defaults derive from the board clock rate.
package debounce_pkg;

  localparam int CLK_HZ = 65_000_000;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISING,
    S_HIGH,
    S_FALLING
  } debounce_state_t;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for asynchronous pin inputs.
// Synchronous active-low reset clears every stage.
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_repeat.sv
// Button debouncer with hold detection and auto-repeat pulses.
// clean_out feeds the rising-edge pulse generator directly.
module debounce_repeat
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int HOLD_CYCLES     = CLK_HZ / 2,
  parameter int REPEAT_CYCLES   = CLK_HZ / 10
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic clean_out,
  output logic held_out,
  output logic repeat_out
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT =
    HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST =
    REP_W'(REPEAT_CYCLES - 1);

  debounce_state_t   state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              sync_out;

  synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (sync_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_LOW;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      rep_cnt    <= '0;
      clean_out  <= 1'b0;
      held_out   <= 1'b0;
      repeat_out <= 1'b0;
    end else begin
      repeat_out <= 1'b0;
      unique case (state)
        S_LOW: begin
          if (sync_out) begin
            state  <= S_RISING;
            db_cnt <= '0;
          end
        end
        S_RISING: begin
          if (!sync_out) begin
            state <= S_LOW;
          end else if (db_cnt == DB_LAST) begin
            state     <= S_HIGH;
            clean_out <= 1'b1;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!sync_out) begin
            state  <= S_FALLING;
            db_cnt <= '0;
          end else if (hold_cnt != HOLD_SAT) begin
            // hold_cnt saturates at the threshold
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              held_out   <= 1'b1;
              repeat_out <= 1'b1;
              rep_cnt    <= '0;
            end
          end else if (rep_cnt == REP_LAST) begin
            repeat_out <= 1'b1;
            rep_cnt    <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        S_FALLING: begin
          // hold and repeat counters stay frozen here
          if (sync_out) begin
            state <= S_HIGH;
          end else if (db_cnt == DB_LAST) begin
            state     <= S_LOW;
            clean_out <= 1'b0;
            held_out  <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= S_LOW;
      endcase
    end
  end

endmodule
